// File: rtl/bus_master_arbiter.sv
// CPU bus master: arbitrates N_CH requesters onto one DV-handshake bus, with byte-lane
// alignment, load sign/zero extension, misalignment/illegal-size detection and a bus timeout.
module bus_master_arbiter #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ARB_RR  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_CH-1:0]        i_req,
  input  logic [N_CH-1:0]        i_we,
  input  logic [3*N_CH-1:0]      i_bhw,
  input  logic [ADDR_W*N_CH-1:0] i_addr,
  input  logic [DATA_W*N_CH-1:0] i_wdata,
  output logic [N_CH-1:0]        o_done,
  output logic                   o_err,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [ADDR_W-1:0]      o_bus_address,
  output logic [DATA_W-1:0]      o_bus_data,
  output logic                   o_bus_DV,
  output logic [2:0]             o_bhw,
  output logic                   o_write_notread,
  input  logic [DATA_W-1:0]      i_bus_data,
  input  logic                   i_bus_DV
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_idx, r_ptr, w_win;
  logic                r_we, r_err;
  logic [2:0]          r_bhw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [CNT_W-1:0]    r_cnt, w_cnt_inc;
  logic                w_any, w_found, w_bad, w_timeout;
  int unsigned         w_j;
  logic [2:0]          w_bhw_ch   [N_CH];
  logic [ADDR_W-1:0]   w_addr_ch  [N_CH];
  logic [DATA_W-1:0]   w_wdata_ch [N_CH];
  logic [2:0]          w_sel_bhw;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_lane_shift, w_ext, w_lane_data;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_bhw_ch[k]   = i_bhw[3*k +: 3];
      w_addr_ch[k]  = i_addr[ADDR_W*k +: ADDR_W];
      w_wdata_ch[k] = i_wdata[DATA_W*k +: DATA_W];
    end
  end

  // Round-robin scans from r_ptr; fixed priority scans from index 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_j     = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_j = (ARB_RR != 0) ? (32'(r_ptr) + k) % N_CH : k;
      if (!w_found && i_req[IDX_W'(w_j)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_j);
      end
    end
  end

  assign w_any      = |i_req;
  assign w_sel_bhw  = w_bhw_ch[w_win];
  assign w_sel_addr = w_addr_ch[w_win];

  always_comb begin
    case (w_sel_bhw)
      3'b000, 3'b100: w_bad = 1'b0;
      3'b001, 3'b101: w_bad = w_sel_addr[0];
      3'b010:         w_bad = |w_sel_addr[1:0];
      default:        w_bad = 1'b1;
    endcase
  end

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

  assign w_lane_shift = i_bus_data >> {r_addr[1:0], 3'b000};
  assign w_byte       = w_lane_shift[7:0];
  assign w_half       = r_addr[1] ? i_bus_data[31:16] : i_bus_data[15:0];

  always_comb begin
    case (r_bhw)
      3'b000:  w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b100:  w_ext = {{(DATA_W-8){1'b0}}, w_byte};
      3'b001:  w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b101:  w_ext = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ext = i_bus_data;
    endcase
  end

  always_comb begin
    case (r_bhw[1:0])
      2'b00:   w_lane_data = {{(DATA_W-8){1'b0}}, r_wdata[7:0]} << {r_addr[1:0], 3'b000};
      2'b01:   w_lane_data = {{(DATA_W-16){1'b0}}, r_wdata[15:0]} << {r_addr[1], 4'b0000};
      default: w_lane_data = r_wdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = w_bad ? S_RESP : S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (i_bus_DV || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Success is tested before timeout so a response on the final WAIT cycle still completes cleanly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_bhw   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_idx   <= w_win;
          r_we    <= i_we[w_win];
          r_bhw   <= w_sel_bhw;
          r_addr  <= w_sel_addr;
          r_wdata <= w_wdata_ch[w_win];
          r_err   <= w_bad;
          r_rdata <= '0;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (i_bus_DV) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? '0 : w_ext;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_RESP: if (ARB_RR != 0) r_ptr <= (32'(r_idx) == N_CH - 1) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_done          = '0;
    o_err           = 1'b0;
    o_rdata         = '0;
    o_bus_address   = '0;
    o_bus_data      = '0;
    o_bus_DV        = 1'b0;
    o_bhw           = '0;
    o_write_notread = 1'b0;
    case (r_state)
      S_REQ, S_WAIT: begin
        o_bus_DV        = (r_state == S_REQ);
        o_bus_address   = {r_addr[ADDR_W-1:2], 2'b00};
        o_bus_data      = r_we ? w_lane_data : '0;
        o_bhw           = r_bhw;
        o_write_notread = r_we;
      end
      S_RESP: begin
        o_done[r_idx] = 1'b1;
        o_err         = r_err;
        o_rdata       = r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus and bus responses.
module tb_bus_master_arbiter;

  typedef struct {logic [1:0] done; logic err; logic [31:0] rdata; int cyc;} exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [2:0] bhw; logic we;} bexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [5:0]  bhw;
  logic [63:0] addr, wdata;
  logic [31:0] bus_data;
  logic        bus_dv;

  logic [1:0]  rr_done, fp_done;
  logic        rr_err, fp_err, rr_bdv, fp_bdv, rr_wnr, fp_wnr;
  logic [31:0] rr_rdata, fp_rdata, rr_baddr, fp_baddr, rr_bdata, fp_bdata;
  logic [2:0]  rr_bhw, fp_bhw;

  exp_t  q_rr[$], q_fp[$];
  bexp_t q_bus[$];
  int    n_tests = 0, n_fail = 0, cyc = 0;
  logic        rsp_en;
  int          rsp_dly;
  logic [31:0] rsp_word;
  int          stray_req = 0, stray_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_master_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_RR(1), .TIMEOUT(4)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_bhw(bhw), .i_addr(addr),
    .i_wdata(wdata), .o_done(rr_done), .o_err(rr_err), .o_rdata(rr_rdata),
    .o_bus_address(rr_baddr), .o_bus_data(rr_bdata), .o_bus_DV(rr_bdv), .o_bhw(rr_bhw),
    .o_write_notread(rr_wnr), .i_bus_data(bus_data), .i_bus_DV(bus_dv));

  bus_master_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_RR(0), .TIMEOUT(4)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_bhw(bhw), .i_addr(addr),
    .i_wdata(wdata), .o_done(fp_done), .o_err(fp_err), .o_rdata(fp_rdata),
    .o_bus_address(fp_baddr), .o_bus_data(fp_bdata), .o_bus_DV(fp_bdv), .o_bhw(fp_bhw),
    .o_write_notread(fp_wnr), .i_bus_data(bus_data), .i_bus_DV(bus_dv));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever a DUT presents o_done or o_bus_DV.
  initial begin
    exp_t  e;
    bexp_t b;
    forever begin
      @(negedge clk);
      if (rr_done != 2'b00) begin
        if (q_rr.size() == 0) chk("rr_unexpected_done", 128'(rr_done), 128'd0);
        else begin
          e = q_rr.pop_front();
          chk("rr_done", 128'(rr_done), 128'(e.done));
          chk("rr_err", 128'(rr_err), 128'(e.err));
          chk("rr_rdata", 128'(rr_rdata), 128'(e.rdata));
          chk("rr_latency", 128'(cyc), 128'(e.cyc));
        end
      end
      if (fp_done != 2'b00) begin
        if (q_fp.size() == 0) chk("fp_unexpected_done", 128'(fp_done), 128'd0);
        else begin
          e = q_fp.pop_front();
          chk("fp_done", 128'(fp_done), 128'(e.done));
          chk("fp_err", 128'(fp_err), 128'(e.err));
          chk("fp_rdata", 128'(fp_rdata), 128'(e.rdata));
          chk("fp_latency", 128'(cyc), 128'(e.cyc));
        end
      end
      if (rr_bdv === 1'b1) begin
        if (q_bus.size() == 0) chk("unexpected_bus_DV", 128'(rr_baddr), 128'd0);
        else begin
          b = q_bus.pop_front();
          chk("bus_address", 128'(rr_baddr), 128'(b.addr));
          chk("bus_data", 128'(rr_bdata), 128'(b.data));
          chk("bus_bhw", 128'(rr_bhw), 128'(b.bhw));
          chk("bus_write_notread", 128'(rr_wnr), 128'(b.we));
        end
      end
    end
  end

  // Bus slave model: answers o_bus_DV after rsp_dly cycles, or emits stray strobes on request.
  initial begin
    bus_dv   = 1'b0;
    bus_data = '0;
    forever begin
      @(negedge clk);
      if (rr_bdv === 1'b1 && rsp_en) begin
        repeat (rsp_dly) @(negedge clk);
        bus_dv   = 1'b1;
        bus_data = rsp_word;
        @(negedge clk);
        bus_dv = 1'b0;
      end else if (stray_req != stray_done) begin
        bus_dv   = 1'b1;
        bus_data = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_dv = 1'b0;
        stray_done++;
      end
    end
  end

  task automatic do_txn(input int ch, input logic w, input logic [2:0] b, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rdata,
                        input logic e_bus, input logic [31:0] e_bdata, input logic r_en,
                        input int r_dly, input logic [31:0] r_word, input int lat);
    exp_t  e;
    bexp_t be;
    logic  got;
    we[ch]          = w;
    bhw[3*ch +: 3]  = b;
    addr[32*ch +: 32]  = a;
    wdata[32*ch +: 32] = wd;
    rsp_en   = r_en;
    rsp_dly  = r_dly;
    rsp_word = r_word;
    e.done  = 2'(1 << ch);
    e.err   = e_err;
    e.rdata = e_rdata;
    e.cyc   = cyc + lat;
    q_rr.push_back(e);
    q_fp.push_back(e);
    if (e_bus) begin
      be.addr = {a[31:2], 2'b00};
      be.data = e_bdata;
      be.bhw  = b;
      be.we   = w;
      q_bus.push_back(be);
    end
    req[ch] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rr_done[ch] === 1'b1) got = 1'b1;
    end
    chk("done_within_bound", 128'(got), 128'd1);
    req[ch] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    exp_t  e;
    bexp_t be;
    int    cnt;
    rst = 1'b1; req = '0; we = '0; bhw = '0; addr = '0; wdata = '0;
    rsp_en = 1'b0; rsp_dly = 1; rsp_word = '0;
    repeat (3) @(negedge clk);
    chk("reset_rr_outputs", {rr_done, rr_err, rr_rdata, rr_baddr, rr_bdata, rr_bdv, rr_bhw, rr_wnr}, '0);
    chk("reset_fp_outputs", {fp_done, fp_err, fp_rdata, fp_baddr, fp_bdata, fp_bdv, fp_bhw, fp_wnr}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Both channels held: RR alternates 0,1,0,1; fixed priority serves ch0 only.
    we = '0; bhw = {3'b010, 3'b010}; addr = {32'h20, 32'h10};
    rsp_en = 1'b1; rsp_dly = 1; rsp_word = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      e.done = (i % 2 == 0) ? 2'b01 : 2'b10; e.err = 1'b0; e.rdata = 32'hDEAD_BEEF;
      e.cyc = cyc + 3 + 4*i;
      q_rr.push_back(e);
      e.done = 2'b01;
      q_fp.push_back(e);
      be.addr = (i % 2 == 0) ? 32'h10 : 32'h20; be.data = '0; be.bhw = 3'b010; be.we = 1'b0;
      q_bus.push_back(be);
    end
    req = 2'b11;
    cnt = 0;
    for (int n = 0; n < 40 && cnt < 4; n++) begin
      @(negedge clk);
      if (rr_done != 2'b00) cnt++;
    end
    chk("arb_grant_count", 128'(cnt), 128'd4);
    req = '0;
    @(negedge clk);

    do_txn(1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1, 32'h0, 1'b1, 2, 32'h80AA_BBCC, 4);
    do_txn(1, 1'b1, 3'b001, 32'h202, 32'h1234, 1'b0, 32'h0, 1'b1, 32'h1234_0000, 1'b1, 1, 32'h5555_5555, 3);
    do_txn(0, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1);
    do_txn(0, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1, 32'h0, 6);
    do_txn(0, 1'b0, 3'b101, 32'h302, 32'h0, 1'b0, 32'h0000_80AA, 1'b1, 32'h0, 1'b1, 4, 32'h80AA_BBCC, 6);
    do_txn(1, 1'b0, 3'b001, 32'h300, 32'h0, 1'b0, 32'hFFFF_F00D, 1'b1, 32'h0, 1'b1, 1, 32'h1234_F00D, 3);
    do_txn(0, 1'b0, 3'b100, 32'h5, 32'h0, 1'b0, 32'h0000_0033, 1'b1, 32'h0, 1'b1, 3, 32'h1122_3344, 5);
    do_txn(1, 1'b1, 3'b000, 32'h7, 32'hFFFF_FFAB, 1'b0, 32'h0, 1'b1, 32'hAB00_0000, 1'b1, 1, 32'h0, 3);
    do_txn(0, 1'b1, 3'b010, 32'h10, 32'hCAFE_BABE, 1'b0, 32'h0, 1'b1, 32'hCAFE_BABE, 1'b1, 2, 32'h0, 4);
    do_txn(1, 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1);
    do_txn(1, 1'b1, 3'b001, 32'h203, 32'h1234, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1);

    stray_req++;
    repeat (3) @(negedge clk);
    do_txn(0, 1'b0, 3'b000, 32'h1, 32'h0, 1'b0, 32'h0000_007F, 1'b1, 32'h0, 1'b1, 1, 32'h0000_7F00, 3);

    // Reset during WAIT: no completion, outputs cleared, late bus strobe ignored.
    we[0] = 1'b0; bhw[2:0] = 3'b010; addr[31:0] = 32'h50;
    rsp_en = 1'b1; rsp_dly = 3; rsp_word = 32'h1357_9BDF;
    be.addr = 32'h50; be.data = '0; be.bhw = 3'b010; be.we = 1'b0;
    q_bus.push_back(be);
    req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wait_addr_stable", 128'(rr_baddr), 128'h50);
    chk("wait_dv_low", 128'(rr_bdv), 128'd0);
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("midrst_rr_outputs", {rr_done, rr_err, rr_rdata, rr_baddr, rr_bdata, rr_bdv, rr_bhw, rr_wnr}, '0);
    chk("midrst_fp_outputs", {fp_done, fp_err, fp_rdata, fp_baddr, fp_bdata, fp_bdv, fp_bhw, fp_wnr}, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    do_txn(1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b1, 1, 32'h0BAD_F00D, 3);

    repeat (2) @(negedge clk);
    chk("rr_pending", 128'(q_rr.size()), 128'd0);
    chk("fp_pending", 128'(q_fp.size()), 128'd0);
    chk("bus_pending", 128'(q_bus.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
